// File: rtl/sr_cmd_gen_pkg.sv
// rtl/sr_cmd_gen_pkg.sv - shared defaults and command encodings for the SR command generator
package sr_cmd_gen_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int CNT_W_DEF           = 8;

  typedef enum logic [1:0] {
    SR_HOLD  = 2'b00,
    SR_RESET = 2'b01,
    SR_SET   = 2'b10
  } sr_cmd_e;

endpackage

// File: rtl/sr_cmd_gen_debounce.sv
// rtl/sr_cmd_gen_debounce.sv - synchronizer, debounce counter and rise-edge pulse for one channel
module sr_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  // Counter stops at DEBOUNCE_CYCLES-1; 8 bits covers the legal 1..255 range.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1;
  logic       sync2;
  logic       state;
  logic [7:0] cnt;

  // Two-flop synchronizer, debounce counter, and a pulse registered on the same edge the state rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= 1'b0;
      cnt   <= 8'd0;
      pulse <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 != state) begin
        if (cnt == CNT_LAST) begin
          state <= sync2;
          cnt   <= 8'd0;
          pulse <= sync2;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= 8'd0;
      end
    end
  end

endmodule

// File: rtl/sr_cmd_gen.sv
// rtl/sr_cmd_gen.sv - debounced set/reset requests arbitrated into one-cycle SR flip-flop pulses
module sr_cmd_gen
  import sr_cmd_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_in,
  input  logic             reset_in,
  output logic             s,
  output logic             r,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic    set_ev;
  logic    rst_ev;
  sr_cmd_e cmd;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (set_in),
    .pulse (set_ev)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (reset_in),
    .pulse (rst_ev)
  );

  // Coincident events cancel out so s and r are never driven together.
  always_comb begin
    cmd = SR_HOLD;
    if (set_ev && !rst_ev) begin
      cmd = SR_SET;
    end else if (rst_ev && !set_ev) begin
      cmd = SR_RESET;
    end
  end

  // Register the command pulses and the conflict flag; the conflict count saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      s            <= 1'b0;
      r            <= 1'b0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      s        <= (cmd == SR_SET);
      r        <= (cmd == SR_RESET);
      conflict <= set_ev && rst_ev;
      if (set_ev && rst_ev && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb/tb_sr_cmd_gen.sv - scoreboard testbench for sr_cmd_gen
module tb_sr_cmd_gen;

  localparam int DB = 4;

  typedef struct {
    logic [2:0] kind;
    int         at_edge;
  } ev_t;

  localparam logic [2:0] K_S = 3'b100;
  localparam logic [2:0] K_R = 3'b010;
  localparam logic [2:0] K_C = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_in;
  logic       reset_in;
  logic       s;
  logic       r;
  logic       conflict;
  logic [7:0] conflict_cnt;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  int  conf_model = 0;
  int  start_edge;
  ev_t exp_q[$];
  ev_t mon_e;

  sr_cmd_gen #(.DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .set_in       (set_in),
    .reset_in     (reset_in),
    .s            (s),
    .r            (r),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input logic [2:0] kind, input int at_edge);
    ev_t e;
    e.kind    = kind;
    e.at_edge = at_edge;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Output monitor: every pulse must match the next expected event, in kind and in edge.
  always @(posedge clk) begin
    #1;
    if (s || r || conflict) begin
      chk("sr_exclusive", {31'd0, s & r}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, s, r, conflict}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ev_kind", {29'd0, s, r, conflict}, {29'd0, mon_e.kind});
        chk("ev_edge", cyc, mon_e.at_edge);
      end
      if (conflict) begin
        conf_model = (conf_model == 255) ? 255 : conf_model + 1;
        chk("conflict_cnt", {24'd0, conflict_cnt}, conf_model);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    set_in   = 1'b1;
    reset_in = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_s", {31'd0, s}, 32'd0);
      chk("rst_r", {31'd0, r}, 32'd0);
      chk("rst_conflict", {31'd0, conflict}, 32'd0);
      chk("rst_cnt", {24'd0, conflict_cnt}, 32'd0);
    end
    @(negedge clk);
    rst      = 1'b0;
    set_in   = 1'b0;
    reset_in = 1'b0;

    // Set press rising before edge 10: s expected after edge 16 only.
    while (cyc < 9) @(negedge clk);
    set_in = 1'b1;
    push(K_S, cyc + DB + 3);
    idle(30);
    set_in = 1'b0;
    idle(12);

    // Reset glitch of 3 synchronized cycles: no pulse.
    reset_in = 1'b1;
    idle(DB - 1);
    reset_in = 1'b0;
    idle(12);

    // Reset press of exactly DB cycles: one r pulse.
    reset_in = 1'b1;
    push(K_R, cyc + DB + 3);
    idle(DB);
    reset_in = 1'b0;
    idle(12);

    // Set then reset one cycle apart: two separate pulses.
    set_in = 1'b1;
    push(K_S, cyc + DB + 3);
    idle(1);
    reset_in = 1'b1;
    push(K_R, cyc + DB + 3);
    idle(10);
    set_in   = 1'b0;
    reset_in = 1'b0;
    idle(12);

    // Simultaneous press: conflict only.
    set_in   = 1'b1;
    reset_in = 1'b1;
    push(K_C, cyc + DB + 3);
    idle(10);
    set_in   = 1'b0;
    reset_in = 1'b0;
    idle(12);
    chk("cnt_after_one", {24'd0, conflict_cnt}, 32'd1);

    // 300 more conflicts: count must saturate at 255.
    for (int i = 0; i < 300; i++) begin
      set_in   = 1'b1;
      reset_in = 1'b1;
      push(K_C, cyc + DB + 3);
      idle(8);
      set_in   = 1'b0;
      reset_in = 1'b0;
      idle(8);
    end
    idle(4);
    chk("cnt_saturated", {24'd0, conflict_cnt}, 32'd255);

    // Reset landing on the edge where s would assert aborts it; held input re-fires 7 edges after release.
    set_in     = 1'b1;
    start_edge = cyc + 1;
    idle(DB + 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    conf_model = 0;
    chk("rst_edge", cyc, start_edge + DB + 2);
    chk("rst_abort_s", {31'd0, s}, 32'd0);
    chk("rst_clr_cnt", {24'd0, conflict_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push(K_S, start_edge + DB + 2 + 7);
    idle(20);
    set_in = 1'b0;
    idle(12);

    chk("pending_events", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_cmd_gen.md
SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, consecutive cycles a synchronized input must differ from its debounced state before that state changes; legal range 1..255.
REQ-002 Parameter: CNT_W, default 8, width of the conflict counter output.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 set_in  input  1  raw asynchronous set request (button/level), active-high.
REQ-006 reset_in  input  1  raw asynchronous reset request (button/level), active-high.
REQ-007 s  output  1  one-cycle set pulse to the downstream SR flip-flop s input.
REQ-008 r  output  1  one-cycle reset pulse to the downstream SR flip-flop r input.
REQ-009 conflict  output  1  one-cycle flag: set and reset events coincided and both were suppressed.
REQ-010 conflict_cnt  output  CNT_W  saturating count of conflict events since reset.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each channel SHALL hold a debounced state and a counter; the counter increments each cycle the synchronized value differs from the debounced state, and clears to 0 in any cycle they match.
REQ-013 When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the debounced state SHALL toggle on that edge and the counter SHALL clear.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change the debounced state.
REQ-015 A 0->1 transition of a channel's debounced state SHALL produce a registered event pulse high for exactly one cycle; 1->0 transitions produce nothing.
REQ-016 Latency: with raw input held high from before rising edge E, s (or r) SHALL be high in the cycle after edge E+DEBOUNCE_CYCLES+2 (i.e. DEBOUNCE_CYCLES+3 edges after first sampling).
REQ-017 Event set only -> s=1, r=0; event reset only -> s=0, r=1; neither -> s=0, r=0.
REQ-018 Both events in the same cycle -> s=0, r=0, conflict=1 for that one cycle; the {s,r}=2'b11 combination SHALL never be driven.
REQ-019 conflict_cnt SHALL increment by 1 per conflict cycle and saturate at 2^CNT_W-1 (no wrap).
REQ-020 An input held high indefinitely SHALL produce exactly one pulse; a new pulse requires a debounced release then re-press.
REQ-021 s, r, conflict SHALL be driven directly from flops (no combinational path from inputs).

Reset
REQ-022 While rst=1 at a rising edge: synchronizer flops, debounced states, counters, s, r, conflict SHALL be 0 and conflict_cnt SHALL be 0.
REQ-023 rst asserted mid-debounce or mid-pulse SHALL abort it; no pulse SHALL be emitted on the edge at which rst is sampled high.
REQ-024 After rst deasserts, an input already held high SHALL be treated as a new press and yield one pulse after the REQ-016 latency.

Structure
REQ-025 A shared package SHALL hold DEBOUNCE_CYCLES default, CNT_W default, and the 2-bit encodings SR_HOLD=00, SR_RESET=01, SR_SET=10.
REQ-026 One sub-module, sr_debounce (synchronizer + debounce counter + rise-edge pulse), SHALL be instantiated twice; arbitration and conflict counter live in sr_cmd_gen.

Verification (DEBOUNCE_CYCLES=4, CNT_W=8)
REQ-027 rst=1 for 2 cycles, set_in=reset_in=1 -> s=r=conflict=0, conflict_cnt=0 throughout reset.
REQ-028 set_in 0->1 before edge 10, held -> s=1 only in the cycle after edge 16, r=0, no further s pulses while held.
REQ-029 reset_in high for 3 synchronized cycles then low -> no r pulse, debounced state stays 0.
REQ-030 set_in and reset_in rise before the same edge -> s=r=0 always, conflict=1 for one cycle, conflict_cnt=1.
REQ-031 Force 300 conflicts -> conflict_cnt stops at 255, no wrap to 0.
REQ-032 set_in held, rst pulsed 1 cycle at the edge where s would assert -> no s that cycle; s pulses again 7 edges after rst release.
